// File: rtl/mem_bist_pkg.sv
// Shared types and defaults for the memory BIST master.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    FINISH
  } state_t;

  localparam int unsigned DEF_SEED    = 32'h0000_000A;
  localparam int unsigned DEF_TIMEOUT = 8;

endpackage

// File: rtl/mem_bist_pattern.sv
// Expected data word for an address: (addr + SEED) mod 2^WIDTH, optionally inverted.
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned SEED       = DEF_SEED
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  inv,
  output logic [WIDTH-1:0]      pattern
);

  logic [WIDTH-1:0] base;

  always_comb begin
    base    = WIDTH'(addr) + WIDTH'(SEED);
    pattern = inv ? ~base : base;
  end

endmodule

// File: rtl/mem_bist_master.sv
// Write-then-read memory BIST master with ready timeout.
// Optional second inverted-pattern pass under `MEM_BIST_INV_PASS_EN.
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned SEED       = DEF_SEED,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wr_data_o,
  input  logic [WIDTH-1:0]      rd_data_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX = '1;
  localparam logic [CW-1:0]         WAIT_LAST = CW'(TIMEOUT - 1);

  state_t                  state;
  logic [CW-1:0]           wait_cnt;
  logic                    inv_now;
  logic [ADDR_WIDTH-1:0]   pat_addr;
  logic                    pat_inv;
  logic [WIDTH-1:0]        pattern;
  logic                    advance;
  logic                    mismatch;

`ifdef MEM_BIST_INV_PASS_EN
  logic inv_pass;
  assign inv_now = inv_pass;
`else
  assign inv_now = 1'b0;
`endif

  // The single pattern generator is steered to whichever address the
  // current state needs: the next write target, or the address being read.
  always_comb begin
    pat_addr = '0;
    pat_inv  = 1'b0;
    case (state)
      WR_GAP: begin
        pat_addr = addr_o + ONE;
        pat_inv  = inv_now;
      end
      RD_REQ: begin
        pat_addr = addr_o;
        pat_inv  = inv_now;
      end
`ifdef MEM_BIST_INV_PASS_EN
      RD_GAP: pat_inv = 1'b1;
`endif
      default: ;
    endcase
  end

  mem_bist_pattern #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEED       (SEED)
  ) u_pattern (
    .addr    (pat_addr),
    .inv     (pat_inv),
    .pattern (pattern)
  );

  always_comb begin
    advance  = 1'b0;
    mismatch = 1'b0;
    case (state)
      WR_REQ, RD_REQ: advance = ready_i;
      WR_GAP, RD_GAP: advance = !ready_i;
      default: ;
    endcase
    mismatch = (rd_data_i != pattern);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      valid_o          <= 1'b0;
      wr_rd_o          <= 1'b0;
      addr_o           <= '0;
      wr_data_o        <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_count_o      <= '0;
      first_err_addr_o <= '0;
      timeout_o        <= 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
      inv_pass         <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state            <= WR_REQ;
            wait_cnt         <= '0;
            addr_o           <= '0;
            wr_rd_o          <= 1'b1;
            wr_data_o        <= pattern;
            valid_o          <= 1'b1;
            busy_o           <= 1'b1;
            pass_o           <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
            inv_pass         <= 1'b0;
`endif
          end
        end
        FINISH: state <= IDLE;
        default: begin
          if (!advance) begin
            // No progress this cycle: abort once the wait budget is spent.
            if (wait_cnt == WAIT_LAST) begin
              state     <= FINISH;
              valid_o   <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              pass_o    <= 1'b0;
              timeout_o <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end else begin
            wait_cnt <= '0;
            case (state)
              WR_REQ: begin
                state   <= WR_GAP;
                valid_o <= 1'b0;
              end
              WR_GAP: begin
                valid_o <= 1'b1;
                if (addr_o == LAST) begin
                  state   <= RD_REQ;
                  addr_o  <= '0;
                  wr_rd_o <= 1'b0;
                end else begin
                  state     <= WR_REQ;
                  addr_o    <= addr_o + ONE;
                  wr_data_o <= pattern;
                end
              end
              RD_REQ: begin
                state   <= RD_GAP;
                valid_o <= 1'b0;
                if (mismatch) begin
                  if (err_count_o == '0) first_err_addr_o <= addr_o;
                  if (err_count_o != ERR_MAX) err_count_o <= err_count_o + 1'b1;
                end
              end
              RD_GAP: begin
                if (addr_o == LAST) begin
`ifdef MEM_BIST_INV_PASS_EN
                  if (!inv_pass) begin
                    state     <= WR_REQ;
                    inv_pass  <= 1'b1;
                    addr_o    <= '0;
                    wr_rd_o   <= 1'b1;
                    wr_data_o <= pattern;
                    valid_o   <= 1'b1;
                  end else
`endif
                  begin
                    state  <= FINISH;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    pass_o <= (err_count_o == '0);
                  end
                end else begin
                  state   <= RD_REQ;
                  addr_o  <= addr_o + ONE;
                  valid_o <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// Scoreboard bench for mem_bist_master with a randomized memory responder.
module tb_mem_bist_master;

  localparam int unsigned WIDTH   = 5;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 5;
  localparam int unsigned SEED    = 10;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned DMASK   = (1 << WIDTH) - 1;
  localparam int unsigned ERR_SAT = (1 << (AW + 1)) - 1;
`ifdef MEM_BIST_INV_PASS_EN
  localparam int unsigned PASSES = 2;
`else
  localparam int unsigned PASSES = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_i = 1'b0;
  logic              valid_o, wr_rd_o, busy_o, done_o, pass_o, timeout_o;
  logic [AW-1:0]     addr_o, first_err_addr_o;
  logic [WIDTH-1:0]  wr_data_o;
  logic [WIDTH-1:0]  rd_data_i = '0;
  logic              ready_i = 1'b0;
  logic [AW:0]       err_count_o;

  always #5 clk = ~clk;

  mem_bist_master #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .SEED       (SEED),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .valid_o          (valid_o),
    .wr_rd_o          (wr_rd_o),
    .addr_o           (addr_o),
    .wr_data_o        (wr_data_o),
    .rd_data_i        (rd_data_i),
    .ready_i          (ready_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_count_o      (err_count_o),
    .first_err_addr_o (first_err_addr_o),
    .timeout_o        (timeout_o)
  );

  typedef struct { logic wr; int unsigned addr; int unsigned data; } txn_t;
  typedef struct { int unsigned err; int unsigned first; logic pass; logic tmo; } res_t;

  txn_t tq[$];
  res_t rq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [31:0]      corrupt   = '0;
  logic [WIDTH-1:0] xr        = '0;
  int               hang_addr = -1;
  int unsigned      max_lat   = 0;
  int unsigned      lat       = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: sequence of accepted transactions and the final verdict of a run.
  task automatic expect_run(input logic [31:0] cmask, input int hang);
    txn_t t;
    res_t r;
    int unsigned errs = 0;
    int first = -1;
    for (int p = 0; p < int'(PASSES); p++) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        if (hang == a) begin
          r.err = 0; r.first = 0; r.pass = 1'b0; r.tmo = 1'b1;
          rq.push_back(r);
          return;
        end
        t.wr = 1'b1;
        t.addr = a;
        t.data = ((a + SEED) & DMASK) ^ ((p != 0) ? DMASK : 0);
        tq.push_back(t);
      end
      for (int a = 0; a < int'(DEPTH); a++) begin
        t.wr = 1'b0; t.addr = a; t.data = 0;
        tq.push_back(t);
        if (cmask[a]) begin
          errs++;
          if (first < 0) first = a;
        end
      end
    end
    r.err   = (errs > ERR_SAT) ? ERR_SAT : errs;
    r.first = (first < 0) ? 0 : first;
    r.pass  = (errs == 0);
    r.tmo   = 1'b0;
    rq.push_back(r);
  endtask

  // Memory responder: random ack latency, optional read corruption and hang.
  initial begin : responder
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        ready_i = 1'b0;
      end else if (valid_o && !ready_i && !(wr_rd_o && int'(addr_o) == hang_addr)) begin
        if (lat > 0) begin
          lat--;
        end else begin
          ready_i = 1'b1;
          if (wr_rd_o) mem[addr_o] = wr_data_o;
          else rd_data_i = mem[addr_o] ^ (corrupt[addr_o] ? xr : '0);
        end
      end else begin
        ready_i = 1'b0;
        lat = $urandom_range(max_lat, 0);
      end
    end
  end

  initial begin : monitor
    txn_t t;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst && valid_o && ready_i) begin
        if (tq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL txn_unexpected: got addr %0d wr %0d, expected no transaction", addr_o, wr_rd_o);
        end else begin
          t = tq.pop_front();
          check("txn_wr", wr_rd_o, t.wr);
          check("txn_addr", addr_o, t.addr);
          if (t.wr) check("txn_wdata", wr_data_o, t.data);
        end
      end
      if (rst && done_o) begin
        if (rq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL done_unexpected: got done pulse, expected none");
        end else begin
          r = rq.pop_front();
          check("err_count", err_count_o, r.err);
          check("first_err_addr", first_err_addr_o, r.first);
          check("pass", pass_o, r.pass);
          check("timeout", timeout_o, r.tmo);
          check("valid_at_done", valid_o, 0);
          check("busy_at_done", busy_o, 0);
          check("txn_left", tq.size(), 0);
        end
      end
    end
  end

  task automatic wait_done();
    int k = 0;
    while (!done_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done_o) begin
      n_cmp++; n_fail++;
      $display("FAIL done_wait: got no done after %0d cycles, expected done", k);
    end
  endtask

  task automatic run(input logic [31:0] cmask, input logic [WIDTH-1:0] x,
                     input int hang, input logic dbl_start);
    int k;
    corrupt = cmask; xr = x; hang_addr = hang;
    expect_run(cmask, hang);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    if (dbl_start) begin
      repeat (10) @(negedge clk);
      check("busy_mid_run", busy_o, 1);
      start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
    end
    if (hang >= 0) begin
      k = 0;
      while (!(valid_o && wr_rd_o && int'(addr_o) == hang) && k < 500) begin
        @(negedge clk);
        k++;
      end
      k = 0;
      while (!done_o && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("timeout_latency", k, TIMEOUT);
    end
    wait_done();
    repeat (4) @(negedge clk);
    check("busy_idle", busy_o, 0);
    hang_addr = -1;
  endtask

  initial begin : stimulus
    int k;
    #12;
    check("reset_outputs", {valid_o, wr_rd_o, addr_o, wr_data_o, busy_o, done_o, pass_o,
                            err_count_o, first_err_addr_o, timeout_o}, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    run(32'h0, 5'h01, -1, 1'b0);
    run(32'h0000_0008, 5'h01, -1, 1'b0);
    run(32'h0000_0220, 5'h01, -1, 1'b0);
    run(32'h0, 5'h01, 3, 1'b0);

    // Asynchronous reset in the middle of the read of address 7.
    max_lat = 1;
    corrupt = '0;
    expect_run(32'h0, -1);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    k = 0;
    while (!(valid_o && !wr_rd_o && addr_o == 7) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("reached_read7", (valid_o && !wr_rd_o && addr_o == 7), 1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", {valid_o, wr_rd_o, addr_o, wr_data_o, busy_o, done_o, pass_o,
                                  err_count_o, first_err_addr_o, timeout_o}, 0);
    tq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run(32'h0, 5'h01, -1, 1'b0);

    run(32'h0, 5'h01, -1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      max_lat = $urandom_range(3, 0);
      run(((i % 3) == 0) ? 32'h0 : ($urandom & $urandom & 32'h0000_FFFF),
          WIDTH'($urandom_range(DMASK, 1)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
